// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: shared types and constants for the SPI register-write controller.
//   state_t      : controller FSM states
//   FRAME_W      : serial frame width (R/W + 7-bit address + 8-bit data)
//   ADDR_*       : register addresses of the companion spi_peripheral
//   make_frame() : packs request fields into the on-wire frame order
package spi_ctrl_pkg;

    localparam int FRAME_W = 16;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    function automatic logic [FRAME_W-1:0] make_frame(input logic       rw,
                                                      input logic [6:0] addr,
                                                      input logic [7:0] wdata);
        return {rw, addr, wdata};
    endfunction

endpackage

// File: rtl/spi_ctrl_if.sv
// spi_ctrl_if: request handshake plus SPI pins of the controller.
//   start/rw/addr/wdata : request from the issuing logic
//   ready/done/rx_data  : status back to the issuing logic
//   ncs/sclk/copi       : SPI outputs toward the peripheral
//   cipo                : SPI input from the peripheral
// Modports: slave = the controller, master = the requesting side / harness.
interface spi_ctrl_if;
    import spi_ctrl_pkg::*;

    logic               start;
    logic               rw;
    logic [6:0]         addr;
    logic [7:0]         wdata;
    logic               ready;
    logic               done;
    logic [FRAME_W-1:0] rx_data;
    logic               ncs;
    logic               sclk;
    logic               copi;
    logic               cipo;

    modport slave (
        input  start, rw, addr, wdata, cipo,
        output ready, done, rx_data, ncs, sclk, copi
    );

    modport master (
        output start, rw, addr, wdata, cipo,
        input  ready, done, rx_data, ncs, sclk, copi
    );

endinterface

// File: rtl/spi_ctrl_clkgen.sv
// spi_ctrl_clkgen: SCLK generator for the SPI controller.
//   clk, rst_n : system clock, synchronous active-low reset
//   en         : run the half-period counter (controller in SHIFT)
//   rise_stb   : high in the cycle whose closing edge raises sclk
//   fall_stb   : high in the cycle whose closing edge lowers sclk
//   sclk       : registered serial clock, idle low
module spi_ctrl_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rise_stb,
    output logic fall_stb,
    output logic sclk
);

    logic [7:0] cnt_q;
    logic       tick;

    // Counter is cleared while disabled, so the first toggle lands
    // exactly CLK_DIV edges after enable.
    assign tick     = en && (cnt_q == 8'(CLK_DIV - 1));
    assign rise_stb = tick && !sclk;
    assign fall_stb = tick && sclk;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else if (!en) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else if (tick) begin
            cnt_q <= '0;
            sclk  <= ~sclk;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator issuing 16-bit register-write frames.
//   clk, rst_n : system clock, synchronous active-low reset
//   bus        : spi_ctrl_if.slave (start/rw/addr/wdata in, ready/done/rx_data
//                out, ncs/sclk/copi out, cipo in)
// Parameters: CLK_DIV (SCLK half-period, 2..255), GAP_CYCLES (nCS-high gap, 1..255).
// Optional feature macro: SPI_CTRL_CIPO_EN builds the CIPO capture register;
// without it rx_data is tied to zero.
module spi_controller
    import spi_ctrl_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input logic       clk,
    input logic       rst_n,
    spi_ctrl_if.slave bus
);

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("spi_controller: CLK_DIV must be in 2..255");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
        $error("spi_controller: GAP_CYCLES must be in 1..255");
    end

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] sr_q;
    logic [4:0]         bit_cnt_q;
    logic [7:0]         tmr_q;
    logic               ncs_q;
    logic               copi_q;
    logic               done_q;

    logic               rise_stb, fall_stb, sclk_w;
    logic               accept, hold_end, gap_end;

    spi_ctrl_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state_q == SHIFT),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .sclk     (sclk_w)
    );

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        hold_end = 1'b0;
        gap_end  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (fall_stb && bit_cnt_q == 5'd15)
                    state_d = HOLD;
            end
            HOLD: begin
                // Keeps nCS low one half-period after the last falling edge.
                if (tmr_q == 8'(CLK_DIV - 1)) begin
                    hold_end = 1'b1;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (tmr_q == 8'(GAP_CYCLES - 1)) begin
                    gap_end = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are updated on the transition edges themselves so that nCS
    // falls and COPI shows bit 15 on the acceptance edge, and COPI changes
    // on the same edge that drops SCLK.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            tmr_q     <= '0;
            ncs_q     <= 1'b1;
            copi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= gap_end;

            if (accept) begin
                sr_q      <= make_frame(bus.rw, bus.addr, bus.wdata);
                bit_cnt_q <= '0;
                ncs_q     <= 1'b0;
                copi_q    <= bus.rw;
            end else if (fall_stb) begin
                sr_q      <= {sr_q[FRAME_W-2:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 5'd1;
                copi_q    <= sr_q[FRAME_W-2];
            end

            if (hold_end) begin
                ncs_q  <= 1'b1;
                copi_q <= 1'b0;
            end

            if (state_d != state_q)
                tmr_q <= '0;
            else if (state_q == HOLD || state_q == GAP)
                tmr_q <= tmr_q + 8'd1;
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.done  = done_q;
    assign bus.ncs   = ncs_q;
    assign bus.sclk  = sclk_w;
    assign bus.copi  = copi_q;

`ifdef SPI_CTRL_CIPO_EN
    logic [FRAME_W-1:0] rx_sh_q;
    logic [FRAME_W-1:0] rx_q;

    // rx_data only moves in the done cycle so readers see a whole frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_sh_q <= '0;
            rx_q    <= '0;
        end else begin
            if (accept)
                rx_sh_q <= '0;
            else if (rise_stb)
                rx_sh_q <= {rx_sh_q[FRAME_W-2:0], bus.cipo};
            if (gap_end)
                rx_q <= rx_sh_q;
        end
    end

    assign bus.rx_data = rx_q;
`else
    logic unused_cipo;
    logic unused_rise;
    assign unused_cipo = bus.cipo;
    assign unused_rise = rise_stb;
    assign bus.rx_data = '0;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed bench for spi_controller (CLK_DIV=4, GAP_CYCLES=4).
// A behavioural peripheral decodes COPI on SCLK rises, commits writes only
// for complete 16-bit frames when nCS rises, and drives CIPO from a pattern.
// Relative cycle c = value sampled at the c-th clock edge after acceptance.
module tb_spi_controller;
    import spi_ctrl_pkg::*;

    localparam int H = 4;
    localparam int G = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_ctrl_if bus ();

    spi_controller #(.CLK_DIV(H), .GAP_CYCLES(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- peripheral model / monitor ----------------
    logic [7:0]  regs [0:127];
    logic        regs_init = 1'b0;
    logic [15:0] pat = 16'hA5C3;
    logic [15:0] shreg, last_frame;
    logic [15:0] rx_at_done;
    logic        prev_ncs = 1'b1, prev_sclk = 1'b0;
    int ncyc = 0, acc_ncyc = 0;
    int nbits = 0, nrise = 0, cidx = 0;
    int fall_rel = -1, rise_rel = -1, first_rise_rel = -1, done_rel = -1;
    int rise_abs = 0, gap = -1, done_cnt = 0;
    logic have_rise = 1'b0;

    always @(negedge clk) begin
        if (!regs_init) begin
            for (int i = 0; i < 128; i++) regs[i] = 8'h00;
            regs_init  = 1'b1;
            bus.cipo   = 1'b0;
            shreg      = '0;
            last_frame = '0;
            rx_at_done = '0;
        end
        ncyc++;
        if (bus.done) begin
            done_cnt++;
            done_rel   = ncyc - acc_ncyc;
            rx_at_done = bus.rx_data;
        end
        if (!bus.ncs && prev_ncs) begin
            fall_rel = ncyc - acc_ncyc;
            if (have_rise) gap = ncyc - rise_abs;
            nbits    = 0;
            cidx     = 0;
            bus.cipo = pat[15];
        end
        if (bus.ncs && !prev_ncs) begin
            rise_rel  = ncyc - acc_ncyc;
            rise_abs  = ncyc;
            have_rise = 1'b1;
            if (nbits == 16) begin
                last_frame = shreg;
                if (shreg[15]) regs[shreg[14:8]] = shreg[7:0];
            end
        end
        if (!bus.ncs && bus.sclk && !prev_sclk) begin
            if (nrise == 0) first_rise_rel = ncyc - acc_ncyc;
            nrise++;
            nbits++;
            shreg = {shreg[14:0], bus.copi};
        end
        if (!bus.ncs && !bus.sclk && prev_sclk) begin
            cidx++;
            if (cidx < 16) bus.cipo = pat[15 - cidx];
        end
        if (rst_n && bus.start && bus.ready) begin
            acc_ncyc = ncyc;
            nrise    = 0;
        end
        prev_ncs  = bus.ncs;
        prev_sclk = bus.sclk;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic s, input logic r, input logic [6:0] a, input logic [7:0] d);
        bus.start = s;
        bus.rw    = r;
        bus.addr  = a;
        bus.wdata = d;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(tag, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic send(input logic r, input logic [6:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        drive(1'b1, r, a, d);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    int d_base;
    logic [15:0] exp_rx;

    initial begin
        drive(1'b0, 1'b0, 7'h00, 8'h00);
`ifdef SPI_CTRL_CIPO_EN
        exp_rx = 16'hA5C3;
`else
        exp_rx = 16'h0000;
`endif
        // reset and idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("rst_ncs",   32'(bus.ncs),     32'd1);
        chk("rst_sclk",  32'(bus.sclk),    32'd0);
        chk("rst_copi",  32'(bus.copi),    32'd0);
        chk("rst_ready", 32'(bus.ready),   32'd1);
        chk("rst_rx",    32'(bus.rx_data), 32'd0);
        chk("rst_done",  32'(done_cnt),    32'd0);

        // single frame: PWM duty = 0x80 -> frame 0x8480
        send(1'b1, ADDR_PWM_DUTY, 8'h80);
        wait_done("f1_done", 400);
        @(negedge clk);
        chk("f1_ncs_fall",   32'(fall_rel),       32'd1);
        chk("f1_ncs_rise",   32'(rise_rel),       32'd133);
        chk("f1_first_rise", 32'(first_rise_rel), 32'd5);
        chk("f1_nrise",      32'(nrise),          32'd16);
        chk("f1_frame",      32'(last_frame),     32'h8480);
        chk("f1_done_cyc",   32'(done_rel),       32'd137);
        chk("f1_reg_duty",   32'(regs[4]),        32'h80);
        chk("f1_rx",         32'(rx_at_done),     32'(exp_rx));

        // back-to-back with start held high
        d_base = done_cnt;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, ADDR_EN_OUT_7_0, 8'hFF);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, ADDR_EN_PWM_7_0, 8'h0F);
        wait_done("b2b_done1", 400);
        #1 bus.start = 1'b0;
        wait_done("b2b_done2", 400);
        @(negedge clk);
        chk("b2b_gap",      32'(gap),             32'(G + 1));
        chk("b2b_reg0",     32'(regs[0]),         32'hFF);
        chk("b2b_reg2",     32'(regs[2]),         32'h0F);
        chk("b2b_done_cnt", 32'(done_cnt - d_base), 32'd2);

        // start pulsed mid-frame is ignored
        d_base = done_cnt;
        send(1'b1, ADDR_EN_PWM_15_8, 8'h5A);
        repeat (40) @(posedge clk);
        #1 drive(1'b1, 1'b1, ADDR_EN_OUT_15_8, 8'h11);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("ign_done", 400);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("ign_frame",    32'(last_frame),        32'h835A);
        chk("ign_done_cnt", 32'(done_cnt - d_base), 32'd1);
        chk("ign_reg1",     32'(regs[1]),           32'h00);
        chk("ign_reg3",     32'(regs[3]),           32'h5A);

        // synchronous reset after 7 SCLK rises
        d_base = done_cnt;
        send(1'b1, ADDR_PWM_DUTY, 8'h33);
        begin
            int n;
            n = 0;
            while (nrise < 7 && n < 200) begin
                @(posedge clk);
                n++;
            end
            chk("mid_reach7", 32'(nrise >= 7), 32'd1);
        end
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_ncs",   32'(bus.ncs),     32'd1);
        chk("mid_sclk",  32'(bus.sclk),    32'd0);
        chk("mid_ready", 32'(bus.ready),   32'd1);
        chk("mid_copi",  32'(bus.copi),    32'd0);
        chk("mid_rx",    32'(bus.rx_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("mid_reg_kept", 32'(regs[4]),           32'h80);
        chk("mid_no_done",  32'(done_cnt - d_base), 32'd0);
        send(1'b1, ADDR_PWM_DUTY, 8'h44);
        wait_done("post_done", 400);
        @(negedge clk);
        chk("post_reg",   32'(regs[4]),    32'h44);
        chk("post_frame", 32'(last_frame), 32'h8444);
        chk("post_rx",    32'(rx_at_done), 32'(exp_rx));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
# spi_controller

SPI mode-0 controller (initiator) that drives the nCS/COPI/SCLK register-write protocol accepted by the team's `spi_peripheral`. It serialises one 16-bit write frame per request: bit 15 is R/W (1 = write), bits 14:8 are the address and bits 7:0 are the data. It sits in companion test designs and loopback harnesses, directly feeding another tile's `ui_in[2:0]`, so PWM and enable registers can be programmed from on-chip logic.

## Interface
Parameters:
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles. Legal range 2..255; elaborate-time error outside it.
- `GAP_CYCLES`, default 4: minimum `clk` cycles nCS stays high between frames. Legal range 1..255.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request strobe; sampled only while `ready`=1.
- `rw`  in  1  frame bit 15 (1 = write).
- `addr`  in  7  register address, frame bits 14:8.
- `wdata`  in  8  write data, frame bits 7:0.
- `ready`  out  1  idle and able to accept `start`.
- `done`  out  1  one-cycle pulse at frame completion.
- `ncs`  out  1  chip select, active-low.
- `sclk`  out  1  serial clock, idle low.
- `copi`  out  1  serial data out, MSB first.
- `cipo`  in  1  serial data in (used only with `SPI_CTRL_CIPO_EN`).
- `rx_data`  out  16  captured CIPO frame.

## Operation
- Reset values: `ncs`=1, `sclk`=0, `copi`=0, `ready`=1, `done`=0, `rx_data`=0. State is IDLE.
- States and transitions:
  - IDLE → SHIFT on `start`&&`ready`: latch {`rw`,`addr`,`wdata`} into a 16-bit shift register, drop `ready`.
  - SHIFT: `ncs`=0. Emit 16 SCLK pulses. `copi` shows the current MSB and updates only on SCLK falling edges.
  - SHIFT → HOLD after the 16th falling edge.
  - HOLD → GAP after `CLK_DIV` cycles, raising `ncs`.
  - GAP → IDLE after `GAP_CYCLES` cycles, pulsing `done` and raising `ready` in the same cycle.
- `copi` returns to 0 on entering GAP.
- `start` while not `ready` is ignored; there is no queueing.
- `start` in the cycle where `done`/`ready` assert is accepted.
- Input fields are sampled only on acceptance. Later changes have no effect on the frame in flight.
- Synchronous reset mid-frame:
  - On the next edge, all outputs return to reset values and the frame is aborted.
  - The peripheral discards the partial frame because nCS rises before 16 bits.
- Counters: half-period counter 8 bits, bit counter 5 bits (0..16). No wrap occurs within legal parameters.

## Timing
Reference points: acceptance edge = cycle 0, H = `CLK_DIV`, G = `GAP_CYCLES`.
- `ncs` falls and `copi`=bit15 at cycle 1.
- SCLK rising edges at cycles 1+H+2kH, k = 0..15; falling edges at 1+2H+2kH.
- Setup and hold of `copi` around each rising edge is ≥ H cycles.
- Last falling edge at 1+32H; `ncs` rises at 1+33H.
- `done`/`ready` assert at 1+33H+G. Frame-to-frame period is 1+33H+G cycles.
- H ≥ 2 keeps each SCLK phase ≥ 2 `clk` cycles, as the peripheral's 2-flop synchroniser requires when sharing `clk`.

## Configuration
- `SPI_CTRL_CIPO_EN` defined:
  - `cipo` is sampled on each SCLK rising edge and shifted MSB-first into a capture register.
  - `rx_data` updates with the full 16 bits in the `done` cycle and holds until the next `done` or reset.
- `SPI_CTRL_CIPO_EN` undefined:
  - No capture logic is built. `rx_data` is tied to 0 and `cipo` is unused (lint-waived).

## Structure
- Package `spi_ctrl_pkg`:
  - state enum {IDLE, SHIFT, HOLD, GAP}.
  - `FRAME_W`=16.
  - register address constants: `ADDR_EN_OUT_7_0`=0x00, `ADDR_EN_OUT_15_8`=0x01, `ADDR_EN_PWM_7_0`=0x02, `ADDR_EN_PWM_15_8`=0x03, `ADDR_PWM_DUTY`=0x04.
- One sub-module, `spi_ctrl_clkgen`:
  - half-period counter, enabled in SHIFT.
  - produces one-cycle `rise_stb`/`fall_stb` and registered `sclk`.
- FSM, shift register and optional capture live in `spi_controller`.

## Test plan
- Reset then idle 20 cycles → `ncs`=1, `sclk`=0, `copi`=0, `ready`=1, `done` never pulses.
- H=4, G=4, start {rw=1, addr=0x04, wdata=0x80} → `ncs` low cycles 1..132, 16 rising edges first at cycle 5, bit stream 0x8480 decoded MSB-first, `done` at cycle 137. A connected `spi_peripheral` reads back `pwm_duty_cycle`=0x80.
- Back-to-back starts (held high) writing 0x00=0xFF then 0x02=0x0F → second `ncs` fall exactly G+1 cycles after first rise. Peripheral registers are 0xFF and 0x0F.
- Pulse `start` during SHIFT with different fields → ignored; transmitted frame unchanged and only one `done`.
- Assert `rst_n`=0 after 7 SCLK rises → next edge `ncs`=1, `sclk`=0, `ready`=1. Peripheral register unchanged; a subsequent frame completes normally.
- With `SPI_CTRL_CIPO_EN`, drive `cipo` with pattern 0xA5C3 aligned to SCLK → `rx_data`=0xA5C3 in the `done` cycle. Without the macro `rx_data`=0.
